// File: rtl/keccak_block_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_block_feeder_pkg
//  Description : Shared widths, block size default and feeder state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package keccak_block_feeder_pkg;

    localparam int KT_WORD_W      = 32;
    localparam int KT_CNT_W       = 6;
    localparam int KT_BLOCK_WORDS = 18;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } feeder_state_e;

endpackage : keccak_block_feeder_pkg
`default_nettype wire

// File: rtl/keccak_word_buf.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_word_buf
//  Description : DEPTH x WORD_W register array, one write port, async read.
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_word_buf #(
    parameter int DEPTH  = 18,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        always_ff @(posedge clk) begin
            if (wr_en && (wr_addr == ADDR_W'(g))) begin
                mem[g] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = mem[i];
            end
        end
    end

endmodule : keccak_word_buf
`default_nettype wire

// File: rtl/keccak_block_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : keccak_block_feeder
//  Description : Collects message words into rate-sized blocks and feeds them
//                to the Keccak hash top in block mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module keccak_block_feeder
    import keccak_block_feeder_pkg::*;
#(
    parameter int BLOCK_WORDS = KT_BLOCK_WORDS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [KT_WORD_W-1:0] s_word,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    input  logic                 kt_busy,
    input  logic                 kt_buffer_full,
    output logic                 kt_mode_block,
    output logic                 kt_start_block,
    output logic [KT_CNT_W-1:0]  kt_words_in_block,
    output logic [KT_WORD_W-1:0] kt_block_word,
    output logic                 kt_block_word_valid,
    output logic                 kt_block_last,
    output logic                 msg_done
);

    localparam logic [KT_CNT_W-1:0] C_FULL_CNT = KT_CNT_W'(BLOCK_WORDS);
    localparam logic [KT_CNT_W-1:0] C_ONE      = KT_CNT_W'(1);

    feeder_state_e         state_q, state_d;
    logic [KT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [KT_CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic                  last_flag_q, last_flag_d;
    logic                  msg_done_q, msg_done_d;

    logic                  buf_wr_en;
    logic [KT_WORD_W-1:0]  buf_rd_data;
    logic                  rd_at_end;

    keccak_word_buf #(
        .DEPTH  (BLOCK_WORDS),
        .WORD_W (KT_WORD_W),
        .ADDR_W (KT_CNT_W)
    ) u_word_buf (
        .clk     (clk),
        .wr_en   (buf_wr_en),
        .wr_addr (cnt_q),
        .wr_data (s_word),
        .rd_addr (rd_ptr_q),
        .rd_data (buf_rd_data)
    );

    assign rd_at_end = (rd_ptr_q == (cnt_q - C_ONE));
    assign msg_done  = msg_done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FILL;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            last_flag_q <= 1'b0;
            msg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            last_flag_q <= last_flag_d;
            msg_done_q  <= msg_done_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        rd_ptr_d            = rd_ptr_q;
        last_flag_d         = last_flag_q;
        msg_done_d          = 1'b0;
        buf_wr_en           = 1'b0;
        s_ready             = 1'b0;
        kt_mode_block       = 1'b0;
        kt_start_block      = 1'b0;
        kt_words_in_block   = '0;
        kt_block_word       = '0;
        kt_block_word_valid = 1'b0;
        kt_block_last       = 1'b0;

        case (state_q)
            ST_FILL: begin
                s_ready   = 1'b1;
                buf_wr_en = s_valid;
                if (s_valid) begin
                    cnt_d = cnt_q + C_ONE;
                    if (s_last) begin
                        last_flag_d = 1'b1;
                    end
                    if (s_last || ((cnt_q + C_ONE) == C_FULL_CNT)) begin
                        state_d = ST_START;
                    end
                end
            end

            ST_START: begin
                kt_mode_block     = 1'b1;
                kt_words_in_block = cnt_q;
                kt_start_block    = !kt_busy && !kt_buffer_full;
                if (kt_start_block) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                kt_mode_block     = 1'b1;
                kt_words_in_block = cnt_q;
                if (kt_busy) begin
                    state_d  = ST_SEND;
                    rd_ptr_d = '0;
                end
            end

            ST_SEND: begin
                kt_mode_block       = 1'b1;
                kt_words_in_block   = cnt_q;
                kt_block_word_valid = 1'b1;
                kt_block_word       = buf_rd_data;
                kt_block_last       = last_flag_q && rd_at_end;
                // A word is only taken while the hash top is absorbing and has room.
                if (kt_busy && !kt_buffer_full) begin
                    if (rd_at_end) begin
                        state_d  = ST_FILL;
                        cnt_d    = '0;
                        rd_ptr_d = '0;
                        if (last_flag_q) begin
                            msg_done_d  = 1'b1;
                            last_flag_d = 1'b0;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + C_ONE;
                    end
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

endmodule : keccak_block_feeder
`default_nettype wire

// File: doc/keccak_block_feeder.md
KECCAK_BLOCK_FEEDER -- requirements
Module: keccak_block_feeder

Interface
REQ-001 Parameter BLOCK_WORDS, default 18, gives the maximum number of 32-bit words per block (576-bit rate).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, asynchronous and active-high.
REQ-004 s_word  input  32  upstream message word.
REQ-005 s_valid  input  1  s_word valid.
REQ-006 s_last  input  1  final word of the message; qualified by s_valid.
REQ-007 s_ready  output  1  feeder accepts a word this cycle.
REQ-008 kt_busy  input  1  busy from the hash top.
REQ-009 kt_buffer_full  input  1  padder-full from the hash top.
REQ-010 kt_mode_block  output  1  block-mode select to the hash top.
REQ-011 kt_start_block  output  1  block-start request.
REQ-012 kt_words_in_block  output  6  word count of the current block.
REQ-013 kt_block_word  output  32  outgoing word.
REQ-014 kt_block_word_valid  output  1  kt_block_word valid.
REQ-015 kt_block_last  output  1  final word of the message.
REQ-016 msg_done  output  1  one-cycle pulse when the final message word is consumed.

Function
REQ-017 The feeder SHALL implement states FILL, START, WAIT, SEND; the reset state is FILL.
REQ-018 In FILL, s_ready = 1 and all kt_* outputs = 0.
  - Each s_valid handshake writes buf[cnt] and increments cnt.
- REQ-019 FILL SHALL go to START on the handshake that carries s_last (sets last_flag) or that makes cnt == BLOCK_WORDS.
REQ-020 In START, WAIT and SEND, s_ready = 0; kt_mode_block = 1; kt_words_in_block = cnt, held constant.
REQ-021 In START, kt_start_block SHALL equal (!kt_busy && !kt_buffer_full), combinationally.
  - The state SHALL move to WAIT on the cycle it is high; otherwise it stays in START.
REQ-022 WAIT SHALL go to SEND, with rd_ptr = 0, on the first cycle kt_busy = 1.
REQ-023 In SEND, the following SHALL hold:
  - kt_block_word_valid = 1.
  - kt_block_word = buf[rd_ptr].
  - kt_block_last = last_flag && (rd_ptr == cnt-1).
REQ-024 A word is consumed on a cycle with kt_busy && !kt_buffer_full in SEND; rd_ptr increments only on consumption.
REQ-025 When word cnt-1 is consumed, the feeder SHALL do the following:
  - Clear cnt and go to FILL.
  - If last_flag is set, pulse msg_done for 1 cycle (the next cycle) and clear last_flag.
REQ-026 While kt_buffer_full = 1, the feeder SHALL hold the current word and valid stable.
  - It SHALL NOT issue kt_start_block.
REQ-027 A message whose length is a multiple of BLOCK_WORDS SHALL end with a full block with kt_block_last on its last word.
  - No empty trailing block is sent.
REQ-028 s_last without an accompanying word is impossible by protocol; cnt is never 0 when leaving FILL.
REQ-029 Minimum latency SHALL be 3 cycles from the block-closing handshake to the first word consumed, when kt_busy = 0 and kt_buffer_full = 0 (START, WAIT, SEND).
  - Thereafter 1 word per cycle.

Reset
REQ-030 Assertion of reset, including mid-block, SHALL asynchronously force the following:
  - State FILL.
  - cnt, rd_ptr and last_flag to 0.
  - All outputs to 0, except s_ready, which is 1 after reset releases.
  - Buffer contents are don't-care.
REQ-031 A block interrupted by reset SHALL be discarded; the hash top is reset by the same signal.

Structure
REQ-032 The shared package SHALL hold the state enum and the constants KT_WORD_W = 32, KT_CNT_W = 6 and the default BLOCK_WORDS = 18.
REQ-033 One sub-module, keccak_word_buf, SHALL be used.
  - It is a BLOCK_WORDS x 32 register array with a write port and an asynchronous read port.
  - The FSM and counters stay in keccak_block_feeder.

Verification
REQ-034 A 3-word message 0x11111111, 0x22222222, 0x33333333 with s_last on the third SHALL produce:
  - One kt_start_block with kt_words_in_block = 3.
  - The three words in order, kt_block_last only on 0x33333333.
  - One msg_done pulse.
REQ-035 A 40-word message SHALL produce blocks of 18, 18 and 4 words; kt_block_last SHALL be set only on word 40.
REQ-036 An 18-word message SHALL produce exactly one block with kt_words_in_block = 18, kt_block_last on word 18, and no second start.
REQ-037 kt_buffer_full held high for 5 cycles in START SHALL give no kt_start_block until it drops.
  - The same stall mid-SEND on word 2 SHALL hold word 2 stable for 5 cycles with no loss or duplication.
REQ-038 Reset asserted during SEND at word 7 of 18 SHALL force outputs to 0 immediately; a following 2-word message SHALL then hash as a fresh single block.
